inst_fetch: RTL and testbench

Instruction fetch unit: the requesting side of the instruction memory port. It holds the program counter and drives the 8-bit byte address to the instruction memory. It captures the returned 32-bit word and buffers it with its PC in a 2-entry queue, which feeds decode over a valid/ready handshake. A redirect input (branch/jump target from execute) flushes the queue and restarts fetch at the new PC.

---
 rtl/inst_fetch.sv | 136 +++++++++++++
 tb/tb_inst_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit, the requesting side of the instruction memory port.
// It holds the fetch PC and drives it to memory as a byte address. Each returned word is
// queued with its PC in a 2-entry FIFO, and the FIFO feeds decode over valid/ready.
// A redirect flushes the queue and restarts fetch at the target PC.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a misaligned redirect sets a sticky misalign_err and halts fetch until rst.
//   undefined : the low two bits of redirect_pc are masked off, and misalign_err is tied to 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   mem_addr        byte address to instruction memory (the fetch PC register)
//   mem_inst        word returned combinationally for mem_addr
//   redirect_valid  load redirect_pc and flush the queue (highest priority)
//   redirect_pc     redirect target byte address
//   out_valid       queue head valid to decode
//   out_ready       decode accepts the head
//   out_inst        head instruction
//   out_pc          head instruction byte address
//   misalign_err    sticky misaligned-redirect flag
module inst_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  mem_addr,
    input  logic [31:0] mem_inst,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [7:0]  out_pc,
    output logic        misalign_err
);

    logic [7:0]  fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] inst_q [2];
    logic [7:0]  pc_q   [2];
    logic        push, pop;
    logic        halted;

`ifdef FETCH_MISALIGN_CHK_EN
    logic halted_q, halted_d;
    logic err_q, err_d;

    assign halted       = halted_q;
    assign misalign_err = err_q;
`else
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // The head's storage stays visible even when no entry is valid.
    assign mem_addr  = fetch_pc_q;
    assign out_inst  = inst_q[rd_ptr_q];
    assign out_pc    = pc_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0) & ~redirect_valid & ~halted;

    always_comb begin
        pop  = out_valid & out_ready;
        // A full queue can still take a word when the head leaves in the same cycle.
        push = ~redirect_valid & ~halted & ((count_q != 2'd2) | pop);

        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
`ifdef FETCH_MISALIGN_CHK_EN
        halted_d   = halted_q;
        err_d      = err_q;
`endif

        if (redirect_valid) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            fetch_pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                halted_d = 1'b1;
                err_d    = 1'b1;
            end
`else
            fetch_pc_d = redirect_pc & 8'hFC;
`endif
        end else begin
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push) begin
                wr_ptr_d   = ~wr_ptr_q;
                fetch_pc_d = fetch_pc_q + 8'd4;  // 8-bit wrap from 8'hFC to 8'h00 is intended
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= 32'h0;
                pc_q[i]   <= 8'h0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                inst_q[wr_ptr_q] <= mem_inst;
                pc_q[wr_ptr_q]   <= fetch_pc_q;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  mem_addr;
    logic [31:0] mem_inst;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [7:0]  out_pc;
    logic        misalign_err;

    logic [31:0] mem [64];
    assign mem_inst = mem[mem_addr[7:2]];

    inst_fetch #(.RESET_PC(8'h00)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: a queue of {inst, pc} plus the next PC to fetch.
    logic [39:0] mq[$];
    logic [7:0]  m_pc;
    bit          m_halt, m_err;

    bit          exp_valid;
    logic [31:0] exp_inst;
    logic [7:0]  exp_pc, exp_addr;
    bit          cur_rv, cur_rdy;
    logic [7:0]  cur_rpc;

    task automatic model_reset();
        mq.delete();
        m_pc   = 8'h00;
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    // Called at posedge+1: drive inputs, go to the negedge, derive expected outputs.
    task automatic settle(input bit rv, input logic [7:0] rpc, input bit rdy);
        cur_rv = rv; cur_rpc = rpc; cur_rdy = rdy;
        redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        @(negedge clk);
        exp_valid = (mq.size() != 0) && !rv && !m_halt;
        exp_inst  = 32'h0;
        exp_pc    = 8'h0;
        if (mq.size() != 0) {exp_inst, exp_pc} = mq[0];
        exp_addr  = m_pc;
    endtask

    // Take the clock edge and apply the architectural effect of this cycle to the model.
    task automatic advance();
        bit pop;
        @(posedge clk);
        pop = exp_valid && cur_rdy;
        if (cur_rv) begin
            mq.delete();
            if (ChkEn && cur_rpc[1:0] != 2'b00) begin
                m_halt = 1'b1;
                m_err  = 1'b1;
                m_pc   = cur_rpc;
            end else begin
                m_pc = cur_rpc & 8'hFC;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halt && mq.size() < 2) begin
                mq.push_back({mem[m_pc[7:2]], m_pc});
                m_pc = m_pc + 8'd4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || mem_addr !== 8'h00 || out_inst !== 32'h0 ||
            out_pc !== 8'h0 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%0b addr=%h inst=%h pc=%h err=%0b, need 0 00 0 00 0",
                     out_valid, mem_addr, out_inst, out_pc, misalign_err);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            settle(1'b0, 8'h00, 1'b1);
            n_cmp++;
            if (out_valid !== exp_valid || mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL stream_ctl[%0d]: valid=%0b addr=%h, need %0b %h",
                         i, out_valid, mem_addr, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                n_cmp++;
                if (out_inst !== exp_inst || out_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: inst=%h pc=%h, need %h %h",
                             i, out_inst, out_pc, exp_inst, exp_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        bit rdy;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rdy = !(i >= 1 && i <= 4) && !(i >= 9);  // stall cycles 1-4, refill at the end
            settle(1'b0, 8'h00, rdy);
            n_cmp++;
            if (out_valid !== exp_valid || mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL bp_ctl[%0d]: valid=%0b addr=%h, need %0b %h",
                         i, out_valid, mem_addr, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                n_cmp++;
                if (out_inst !== exp_inst || out_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL bp_data[%0d]: inst=%h pc=%h, need %h %h",
                             i, out_inst, out_pc, exp_inst, exp_pc);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (mem_addr !== 8'h08) begin
                    n_fail++;
                    $display("FAIL bp_hold_addr: addr=%h, need 08", mem_addr);
                end
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 5; i++) begin
            settle(i == 0, 8'h48, 1'b1);
            n_cmp++;
            if (out_valid !== exp_valid || mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL redir_ctl[%0d]: valid=%0b addr=%h, need %0b %h",
                         i, out_valid, mem_addr, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                n_cmp++;
                if (out_inst !== exp_inst || out_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL redir_data[%0d]: inst=%h pc=%h, need %h %h",
                             i, out_inst, out_pc, exp_inst, exp_pc);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== 8'h48 || out_inst !== 32'h02b02823) begin
                    n_fail++;
                    $display("FAIL redir_target: valid=%0b pc=%h inst=%h, need 1 48 02b02823",
                             out_valid, out_pc, out_inst);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            settle(i == 0, 8'hFC, 1'b1);
            n_cmp++;
            if (out_valid !== exp_valid || mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL wrap_ctl[%0d]: valid=%0b addr=%h, need %0b %h",
                         i, out_valid, mem_addr, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                n_cmp++;
                if (out_inst !== exp_inst || out_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL wrap_data[%0d]: inst=%h pc=%h, need %h %h",
                             i, out_inst, out_pc, exp_inst, exp_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit         rv;
        logic [7:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 8'($urandom_range(0, 63)) << 2;
            settle(rv, rpc, 1'($urandom_range(0, 1)));
            n_cmp++;
            if (out_valid !== exp_valid || mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rand_ctl[%0d]: valid=%0b addr=%h, need %0b %h",
                         i, out_valid, mem_addr, exp_valid, exp_addr);
            end
            if (exp_valid) begin
                n_cmp++;
                if (out_inst !== exp_inst || out_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: inst=%h pc=%h, need %h %h",
                             i, out_inst, out_pc, exp_inst, exp_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        // Stall long enough to fill the queue, then reset between edges.
        for (int i = 0; i < 3; i++) begin
            settle(1'b0, 8'h00, 1'b0);
            advance();
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || mem_addr !== 8'h00 || out_inst !== 32'h0 || out_pc !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b addr=%h inst=%h pc=%h, need 0 00 0 00",
                     out_valid, mem_addr, out_inst, out_pc);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        test_stream();
    endtask

    task automatic test_misalign();
        for (int i = 0; i < 6; i++) begin
            settle(i == 0, 8'h0A, 1'b1);
            n_cmp++;
            if (out_valid !== exp_valid || mem_addr !== exp_addr || misalign_err !== m_err) begin
                n_fail++;
                $display("FAIL misalign_ctl[%0d]: valid=%0b addr=%h err=%0b, need %0b %h %0b",
                         i, out_valid, mem_addr, misalign_err, exp_valid, exp_addr, m_err);
            end
            if (exp_valid) begin
                n_cmp++;
                if (out_inst !== exp_inst || out_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL misalign_data[%0d]: inst=%h pc=%h, need %h %h",
                             i, out_inst, out_pc, exp_inst, exp_pc);
                end
            end
            advance();
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (misalign_err !== 1'b0 || out_valid !== 1'b0 || mem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL misalign_clear: err=%0b valid=%0b addr=%h, need 0 0 00",
                     misalign_err, out_valid, mem_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0]  = 32'h00007033;
        mem[1]  = 32'h00100093;
        mem[18] = 32'h02b02823;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_random();
        test_async_reset();
        test_misalign();
        test_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
